// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transmit path.
// Feeder FSM encoding and timing constants live here.
package spi_pkg;

  localparam int SPI_DW        = 12;
  localparam int FD_TIMEOUT    = 64;
  localparam int FD_GAP_CYCLES = 4;

  typedef enum logic [1:0] {
    FD_IDLE,
    FD_REQ,
    FD_XFER,
    FD_GAP
  } feeder_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// DEPTH is a power of two so the pointers wrap naturally.
module spi_sync_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign level   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Feeds queued words to the SPI master, one frame per word,
// pacing newd/din against the master's synchronized cs.
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int DW         = SPI_DW,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = FD_GAP_CYCLES,
  parameter int TIMEOUT    = FD_TIMEOUT,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          newd,
  output logic [DW-1:0] din,
  input  logic          cs,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic          sent,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  feeder_state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [DW-1:0] din_q, din_d;
  logic          newd_q, newd_d;
  logic          busy_q, busy_d;
  logic          sent_q, sent_d;
  logic          err_q, err_d;
  logic          cs_m_q, cs_s_q;
  logic          full, empty, pop;
  logic [DW-1:0] rdata;

  spi_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .pop   (pop),
    .wdata (s_data),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign s_ready = !full;
  assign newd    = newd_q;
  assign din     = din_q;
  assign busy    = busy_q;
  assign sent    = sent_q;
  assign err     = err_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    din_d   = din_q;
    newd_d  = newd_q;
    sent_d  = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      FD_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          din_d   = rdata;
          newd_d  = 1'b1;
          tcnt_d  = '0;
          state_d = FD_REQ;
        end
      end
      FD_REQ: begin
        if (!cs_s_q) begin
          newd_d  = 1'b0;
          state_d = FD_XFER;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          newd_d  = 1'b0;
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = FD_GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      FD_XFER: begin
        if (cs_s_q) begin
          sent_d  = 1'b1;
          gcnt_d  = '0;
          state_d = FD_GAP;
        end
      end
      FD_GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = FD_IDLE;
        else gcnt_d = gcnt_q + 1'b1;
      end
      default: state_d = FD_IDLE;
    endcase
    busy_d = (state_d != FD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FD_IDLE;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      din_q   <= '0;
      newd_q  <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_m_q  <= 1'b1;
      cs_s_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      din_q   <= din_d;
      newd_q  <= newd_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      cs_m_q  <= cs;
      cs_s_q  <= cs_m_q;
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder with a behavioural SPI master/slave.
// The master captures din on newd and holds cs low for a fixed frame.
module tb_spi_tx_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        newd;
  logic [11:0] din;
  logic        cs = 1'b1;
  logic        busy;
  logic [3:0]  level;
  logic        sent;
  logic        err;

  logic        mst_en;
  logic [11:0] rx [$];
  int          resend_n = 0;
  int          sent_n = 0;
  int          err_n = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  int          min_gap = 1000;
  logic        cs_prev = 1'b1;
  logic        newd_prev = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  spi_tx_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .newd    (newd),
    .din     (din),
    .cs      (cs),
    .busy    (busy),
    .level   (level),
    .sent    (sent),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Master: start a frame when idle and newd is seen, 24-cycle cs low.
  always begin
    @(posedge clk);
    #1;
    if (mst_en && newd && !rst) begin
      rx.push_back(din);
      repeat (2) @(posedge clk);
      #1 cs = 1'b0;
      repeat (24) @(posedge clk);
      #1 cs = 1'b1;
      if (newd) resend_n++;
      repeat (2) @(posedge clk);
    end
  end

  always @(negedge clk) begin
    if (sent) sent_n++;
    if (err) err_n++;
    if (cs && !cs_prev) rise_cyc = cyc;
    if (newd && !newd_prev && rise_cyc >= 0 && (cyc - rise_cyc) < min_gap)
      min_gap = cyc - rise_cyc;
    cs_prev   = cs;
    newd_prev = newd;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int s0, e0, rb, t0, n, acc, first_block;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    mst_en = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_newd", newd, 0);
    chk("rst_din", din, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Single word
    s0 = sent_n; e0 = err_n; rb = rx.size();
    @(negedge clk);
    s_valid = 1'b1; s_data = 12'hA5C;
    @(negedge clk);
    s_valid = 1'b0;
    chk("single_level_push", level, 1);
    chk("single_newd_early", newd, 0);
    @(negedge clk);
    chk("single_newd", newd, 1);
    chk("single_din", din, 12'hA5C);
    chk("single_busy", busy, 1);
    for (int i = 0; i < 100 && cs !== 1'b0; i++) @(negedge clk);
    chk("single_cs_fall", cs, 0);
    t0 = cyc;
    for (int i = 0; i < 100 && newd !== 1'b0; i++) @(negedge clk);
    chk("single_cs_to_newd", cyc - t0, 3);
    chk("single_din_hold", din, 12'hA5C);
    for (int i = 0; i < 200 && sent_n == s0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("single_sent_n", sent_n - s0, 1);
    chk("single_err_n", err_n - e0, 0);
    chk("single_rx", rx_at(rb), 12'hA5C);
    chk("single_rx_n", rx.size() - rb, 1);

    // Burst with backpressure
    s0 = sent_n; rb = rx.size(); acc = 0; first_block = -1;
    @(negedge clk);
    s_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      s_data = 12'(k);
      for (int t = 0; t < 2000 && !s_ready; t++) begin
        if (first_block < 0) first_block = acc;
        @(negedge clk);
      end
      @(negedge clk);
      acc++;
    end
    s_valid = 1'b0;
    chk("burst_block_at", first_block, 9);
    for (int i = 0; i < 3000 && sent_n < s0 + 10; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("burst_sent_n", sent_n - s0, 10);
    chk("burst_rx_n", rx.size() - rb, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("burst_w%0d", i + 1), rx_at(rb + i), i + 1);
    chk("burst_gap", min_gap, 8);
    chk("burst_resend", resend_n, 0);
    chk("burst_level", level, 0);

    // Timeout with cs stuck high
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    mst_en = 1'b0;
    s0 = sent_n; e0 = err_n; rb = rx.size();
    s_valid = 1'b1; s_data = 12'h123;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < 10 && !newd; i++) @(negedge clk);
    chk("tmo_din", din, 12'h123);
    n = 0;
    while (newd && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_newd_cycles", n, 64);
    repeat (10) @(negedge clk);
    chk("tmo_err_n", err_n - e0, 1);
    chk("tmo_sent_n", sent_n - s0, 0);
    chk("tmo_level", level, 0);
    chk("tmo_busy", busy, 0);
    mst_en = 1'b1;

    // Reset in the middle of a transfer
    s0 = sent_n;
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 12'h200 + 12'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 100 && cs !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 100 && newd !== 1'b0; i++) @(negedge clk);
    chk("rmid_level_pre", level, 3);
    chk("rmid_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_newd", newd, 0);
    chk("rmid_level", level, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_din", din, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rmid_no_sent", sent_n - s0, 0);
    chk("rmid_idle", busy, 0);

    // Push on the same edge as the IDLE pop
    s0 = sent_n; rb = rx.size();
    s_valid = 1'b1; s_data = 12'h3C1;
    @(negedge clk);
    chk("coll_level_a", level, 1);
    chk("coll_busy_a", busy, 0);
    s_data = 12'h3C2;
    @(negedge clk);
    s_valid = 1'b0;
    chk("coll_level_b", level, 1);
    chk("coll_din", din, 12'h3C1);
    chk("coll_newd", newd, 1);
    for (int i = 0; i < 500 && sent_n < s0 + 2; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("coll_sent_n", sent_n - s0, 2);
    chk("coll_rx0", rx_at(rb), 12'h3C1);
    chk("coll_rx1", rx_at(rb + 1), 12'h3C2);
    chk("coll_level_end", level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
